// File: rtl/scale_arbiter.sv
// Shares one scale unit between two requesters: round-robin issue on the way in,
// tag-queue steering of results back to the requester's own destination.
module scale_arbiter #(
  parameter int TAG_DEPTH = 8
) (
  input  logic               clock,
  input  logic               reset,
  input  logic signed [31:0] r0_x [2:0],
  input  logic signed [31:0] r0_a,
  input  logic               r0_empty,
  output logic               r0_rd_en,
  input  logic signed [31:0] r1_x [2:0],
  input  logic signed [31:0] r1_a,
  input  logic               r1_empty,
  output logic               r1_rd_en,
  output logic signed [31:0] s_x [2:0],
  output logic signed [31:0] s_a,
  output logic               s_empty,
  input  logic               s_rd_en,
  input  logic signed [31:0] s_out [2:0],
  input  logic               s_out_empty,
  output logic               s_out_rd_en,
  output logic signed [31:0] o0_dout [2:0],
  output logic               o0_wr_en,
  input  logic               o0_full,
  output logic signed [31:0] o1_dout [2:0],
  output logic               o1_wr_en,
  input  logic               o1_full
);

  localparam int PW = $clog2(TAG_DEPTH);

  typedef enum logic {IDLE, PRESENT} state_t;

  state_t      state;
  logic        grant;
  logic        last_served;
  logic        tag_mem [TAG_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW:0]   tag_count;

  logic tag_full;
  logic tag_empty;
  logic present;
  logic issue;
  logic head_tag;
  logic head_full;
  logic ret;

  // Strobes are gated by reset so nothing pops or writes in a reset cycle.
  always_comb begin
    tag_full  = (tag_count == (PW+1)'(TAG_DEPTH));
    tag_empty = (tag_count == '0);
    present   = reset && (state == PRESENT);
    issue     = present && s_rd_en;
    head_tag  = tag_mem[rd_ptr];
    head_full = head_tag ? o1_full : o0_full;
    ret       = reset && !s_out_empty && !tag_empty && !head_full;
  end

  always_comb begin
    s_empty = !present;
    s_a     = '0;
    for (int i = 0; i < 3; i++) begin
      s_x[i]     = '0;
      o0_dout[i] = s_out[i];
      o1_dout[i] = s_out[i];
    end
    if (present) begin
      s_a = grant ? r1_a : r0_a;
      for (int i = 0; i < 3; i++) begin
        s_x[i] = grant ? r1_x[i] : r0_x[i];
      end
    end
    r0_rd_en    = issue && !grant;
    r1_rd_en    = issue && grant;
    s_out_rd_en = ret;
    o0_wr_en    = ret && !head_tag;
    o1_wr_en    = ret && head_tag;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state       <= IDLE;
      grant       <= 1'b0;
      last_served <= 1'b1;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      tag_count   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (!tag_full && (!r0_empty || !r1_empty)) begin
            // With a single candidate, r0_empty doubles as "pick r1".
            grant <= (!r0_empty && !r1_empty) ? ~last_served : r0_empty;
            state <= PRESENT;
          end
        end
        PRESENT: begin
          if (s_rd_en) begin
            last_served <= grant;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase

      if (issue) begin
        tag_mem[wr_ptr] <= grant;
        wr_ptr          <= wr_ptr + 1'b1;
      end
      if (ret) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({issue, ret})
        2'b10:   tag_count <= tag_count + 1'b1;
        2'b01:   tag_count <= tag_count - 1'b1;
        default: tag_count <= tag_count;
      endcase
    end
  end

endmodule

// File: tb/tb_scale_arbiter.sv
// Randomized bench for scale_arbiter: models requester FIFOs, the scale unit and the
// destinations, and predicts every strobe and data word from transaction-level rules.
module tb_scale_arbiter;

  localparam int TAG_DEPTH = 8;

  logic clock = 1'b0;
  logic reset;
  logic signed [31:0] r0_x [2:0];
  logic signed [31:0] r1_x [2:0];
  logic signed [31:0] s_x [2:0];
  logic signed [31:0] s_out [2:0];
  logic signed [31:0] o0_dout [2:0];
  logic signed [31:0] o1_dout [2:0];
  logic signed [31:0] r0_a, r1_a, s_a;
  logic r0_empty, r1_empty, r0_rd_en, r1_rd_en;
  logic s_empty, s_rd_en, s_out_empty, s_out_rd_en;
  logic o0_wr_en, o1_wr_en, o0_full, o1_full;

  always #5 clock = ~clock;

  scale_arbiter #(.TAG_DEPTH(TAG_DEPTH)) dut (
    .clock(clock), .reset(reset),
    .r0_x(r0_x), .r0_a(r0_a), .r0_empty(r0_empty), .r0_rd_en(r0_rd_en),
    .r1_x(r1_x), .r1_a(r1_a), .r1_empty(r1_empty), .r1_rd_en(r1_rd_en),
    .s_x(s_x), .s_a(s_a), .s_empty(s_empty), .s_rd_en(s_rd_en),
    .s_out(s_out), .s_out_empty(s_out_empty), .s_out_rd_en(s_out_rd_en),
    .o0_dout(o0_dout), .o0_wr_en(o0_wr_en), .o0_full(o0_full),
    .o1_dout(o1_dout), .o1_wr_en(o1_wr_en), .o1_full(o1_full)
  );

  int total = 0;
  int bad = 0;

  // Items are packed {a, x2, x1, x0}; results {x2, x1, x0}.
  logic [127:0] r0q [$];
  logic [127:0] r1q [$];
  logic [95:0]  exp0 [$];
  logic [95:0]  exp1 [$];
  logic [95:0]  res_q [$];
  int           res_t [$];
  logic         tags_q [$];
  int cyc = 0;
  logic last_served = 1'b1;
  logic cur_grant = 1'b0;

  logic sn_rst = 1'b1, sn_idle = 1'b1, sn_full = 1'b0, sn_issued = 1'b0;
  logic sn_e0 = 1'b1, sn_e1 = 1'b1, sn_last = 1'b1;

  int rd_mode = 0, f0_mode = 0, f1_mode = 0, lat_max = 2;
  bit stall = 0, stray = 0, want_first = 0;
  int w0, w1, nw, issues;
  logic [15:0]  dlog;
  logic [95:0]  last_o0;
  logic [1:0]   first_rd;

  task automatic checkOutput(input string tag, input logic [127:0] observed, input logic [127:0] expected);
    total++;
    if (observed !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %h want %h", tag, observed, expected);
    end
  endtask

  function automatic logic [95:0] scaleItem(input logic [127:0] it);
    logic [95:0] r;
    logic signed [63:0] p;
    logic signed [31:0] a;
    a = it[127:96];
    for (int i = 0; i < 3; i++) begin
      p = longint'($signed(it[i*32 +: 32])) * longint'(a);
      r[i*32 +: 32] = p[47:16];
    end
    return r;
  endfunction

  function automatic logic [127:0] randItem();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic pushReq(input int k, input logic [127:0] it);
    if (k == 0) begin
      r0q.push_back(it);
      exp0.push_back(scaleItem(it));
    end else begin
      r1q.push_back(it);
      exp1.push_back(scaleItem(it));
    end
  endtask

  task automatic resetCounters();
    w0 = 0; w1 = 0; nw = 0; issues = 0; dlog = '0; last_o0 = '0;
  endtask

  task automatic driveInputs();
    logic [127:0] h0, h1;
    logic [95:0]  hr;
    h0 = (r0q.size() != 0) ? r0q[0] : '0;
    h1 = (r1q.size() != 0) ? r1q[0] : '0;
    r0_empty = (r0q.size() == 0);
    r1_empty = (r1q.size() == 0);
    for (int i = 0; i < 3; i++) begin
      r0_x[i] = h0[i*32 +: 32];
      r1_x[i] = h1[i*32 +: 32];
    end
    r0_a = h0[127:96];
    r1_a = h1[127:96];
    if (stray) begin
      s_out_empty = 1'b0;
      hr = 96'h0BAD0000_0BAD0000_0BAD0000;
    end else begin
      s_out_empty = stall || (res_q.size() == 0) || (res_t[0] > cyc);
      hr = (res_q.size() != 0) ? res_q[0] : '0;
    end
    for (int i = 0; i < 3; i++) s_out[i] = hr[i*32 +: 32];
    s_rd_en = (rd_mode == 1) || (rd_mode == 2 && $urandom_range(0, 1) == 1);
    o0_full = (f0_mode == 1) || (f0_mode == 2 && $urandom_range(0, 3) == 0);
    o1_full = (f1_mode == 1) || (f1_mode == 2 && $urandom_range(0, 3) == 0);
  endtask

  // One clock: predict and compare at the falling edge, advance the model after the rising edge.
  task automatic applyStimulus();
    logic exp_idle, issued_now, exp_spop, head;
    logic [127:0] front;
    logic [95:0]  sv;
    @(negedge clock);
    if (sn_rst) exp_idle = 1'b1;
    else if (sn_idle) begin
      exp_idle = !(!sn_full && (!sn_e0 || !sn_e1));
      if (!exp_idle) cur_grant = (!sn_e0 && !sn_e1) ? !sn_last : sn_e0;
    end else exp_idle = sn_issued;

    checkOutput("s_empty", s_empty, (reset && !exp_idle) ? 1'b0 : 1'b1);
    front = '0;
    if (reset && !exp_idle)
      front = cur_grant ? ((r1q.size() != 0) ? r1q[0] : '0) : ((r0q.size() != 0) ? r0q[0] : '0);
    checkOutput("s_data", {s_a, s_x[2], s_x[1], s_x[0]}, front);
    issued_now = reset && !exp_idle && s_rd_en;
    checkOutput("rd_en", {r1_rd_en, r0_rd_en},
                issued_now ? (cur_grant ? 2'b10 : 2'b01) : 2'b00);

    head = (tags_q.size() != 0) ? tags_q[0] : 1'b0;
    exp_spop = reset && !s_out_empty && (tags_q.size() != 0) && !(head ? o1_full : o0_full);
    checkOutput("ret_strobes", {s_out_rd_en, o1_wr_en, o0_wr_en},
                {exp_spop, exp_spop && head, exp_spop && !head});
    sv = {s_out[2], s_out[1], s_out[0]};
    checkOutput("dout", {o1_dout[2], o1_dout[1], o1_dout[0], o0_dout[2], o0_dout[1], o0_dout[0]},
                {sv, sv});
    if (exp_spop) begin
      if (head) begin
        checkOutput("o1_avail", exp1.size() != 0, 1'b1);
        if (exp1.size() != 0) checkOutput("o1_data", sv, exp1.pop_front());
      end else begin
        checkOutput("o0_avail", exp0.size() != 0, 1'b1);
        if (exp0.size() != 0) checkOutput("o0_data", sv, exp0.pop_front());
      end
    end

    if (o0_wr_en) begin w0++; last_o0 = {o0_dout[2], o0_dout[1], o0_dout[0]}; end
    if (o1_wr_en) w1++;
    if ((o0_wr_en || o1_wr_en) && nw < 16) begin dlog[nw] = o1_wr_en; nw++; end
    if (r0_rd_en || r1_rd_en) issues++;
    if (want_first && (r0_rd_en || r1_rd_en)) begin first_rd = {r1_rd_en, r0_rd_en}; want_first = 0; end

    sn_rst    = !reset;
    sn_idle   = exp_idle;
    sn_issued = issued_now;
    sn_full   = (tags_q.size() == TAG_DEPTH);
    sn_e0     = (r0q.size() == 0);
    sn_e1     = (r1q.size() == 0);
    sn_last   = last_served;

    @(posedge clock);
    #1;
    cyc++;
    if (sn_rst) begin
      r0q.delete(); r1q.delete(); exp0.delete(); exp1.delete();
      res_q.delete(); res_t.delete(); tags_q.delete();
      last_served = 1'b1;
      cur_grant = 1'b0;
    end else begin
      if (exp_spop) begin
        void'(res_q.pop_front());
        void'(res_t.pop_front());
        void'(tags_q.pop_front());
      end
      if (issued_now) begin
        if (cur_grant) void'(r1q.pop_front());
        else void'(r0q.pop_front());
        res_q.push_back(scaleItem(front));
        res_t.push_back(cyc + $urandom_range(1, lat_max));
        tags_q.push_back(cur_grant);
        last_served = cur_grant;
      end
    end
    driveInputs();
  endtask

  task automatic pulseReset();
    reset = 1'b0;
    applyStimulus();
    reset = 1'b1;
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b0;
    resetCounters();
    first_rd = 2'b00;
    driveInputs();
    repeat (3) applyStimulus();
    reset = 1'b1;
    repeat (2) applyStimulus();

    $display("[TB] single r0 request");
    resetCounters();
    pushReq(0, {32'h00018000, 32'hFFFF0000, 32'h00010000, 32'h00020000});
    rd_mode = 1;
    driveInputs();
    repeat (20) applyStimulus();
    checkOutput("single_w0", w0, 1);
    checkOutput("single_w1", w1, 0);
    checkOutput("single_data", last_o0, 96'hFFFE8000_00018000_00030000);

    $display("[TB] round robin from reset");
    pulseReset();
    resetCounters();
    for (int i = 0; i < 4; i++) begin pushReq(0, randItem()); pushReq(1, randItem()); end
    driveInputs();
    repeat (40) applyStimulus();
    checkOutput("rr_count", nw, 8);
    checkOutput("rr_order", dlog[7:0], 8'hAA);

    $display("[TB] o1 full stall");
    resetCounters();
    f1_mode = 1;
    pushReq(1, randItem());
    driveInputs();
    repeat (6) applyStimulus();
    pushReq(0, randItem()); pushReq(0, randItem());
    driveInputs();
    repeat (30) applyStimulus();
    checkOutput("stall_writes", w0 + w1, 0);
    checkOutput("stall_spop", s_out_rd_en, 1'b0);
    f1_mode = 0;
    driveInputs();
    repeat (40) applyStimulus();
    checkOutput("drain_w1", w1, 1);
    checkOutput("drain_w0", w0, 2);
    checkOutput("drain_left", exp0.size() + exp1.size(), 0);

    $display("[TB] tag queue full");
    resetCounters();
    stall = 1;
    for (int i = 0; i < 12; i++) begin pushReq(0, randItem()); pushReq(1, randItem()); end
    driveInputs();
    repeat (60) applyStimulus();
    checkOutput("full_issues", issues, TAG_DEPTH);
    checkOutput("full_s_empty", s_empty, 1'b1);
    stall = 0;
    driveInputs();
    repeat (150) applyStimulus();
    checkOutput("full_drain", exp0.size() + exp1.size(), 0);

    $display("[TB] reset with tags in flight");
    stall = 1;
    for (int i = 0; i < 5; i++) begin pushReq(0, randItem()); pushReq(1, randItem()); end
    driveInputs();
    for (int i = 0; i < 100 && tags_q.size() < 3; i++) applyStimulus();
    rd_mode = 0;
    driveInputs();
    checkOutput("fill3", tags_q.size(), 3);
    for (int i = 0; i < 10 && s_empty; i++) applyStimulus();
    checkOutput("present_before_rst", s_empty, 1'b0);
    pulseReset();
    stall = 0;
    resetCounters();
    stray = 1;
    driveInputs();
    repeat (3) applyStimulus();
    stray = 0;
    checkOutput("no_stray_pop", w0 + w1, 0);
    want_first = 1;
    first_rd = 2'b00;
    pushReq(0, randItem()); pushReq(1, randItem());
    pushReq(0, randItem()); pushReq(1, randItem());
    rd_mode = 1;
    driveInputs();
    repeat (30) applyStimulus();
    checkOutput("first_after_rst", first_rd, 2'b01);
    checkOutput("rst_drain", exp0.size() + exp1.size(), 0);

    $display("[TB] random traffic");
    rd_mode = 2; f0_mode = 2; f1_mode = 2; lat_max = 4;
    for (int c = 0; c < 3000; c++) begin
      stall = ($urandom_range(0, 4) == 0);
      if ($urandom_range(0, 2) == 0 && r0q.size() < 6) pushReq(0, randItem());
      if ($urandom_range(0, 2) == 0 && r1q.size() < 6) pushReq(1, randItem());
      driveInputs();
      applyStimulus();
    end
    rd_mode = 1; f0_mode = 0; f1_mode = 0; stall = 0;
    driveInputs();
    repeat (200) applyStimulus();
    checkOutput("rand_drain_exp", exp0.size() + exp1.size(), 0);
    checkOutput("rand_drain_req", r0q.size() + r1q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
